// File: rtl/fetch_stage.sv
// fetch_stage: LC-3b IF stage owning the PC, the imem request and the IF/ID register.
// Optional perf counters (fetch_count, stall_count) are built when FETCH_PERF_EN is defined.
`default_nettype none

module fetch_stage #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter logic [15:0] NOP_IR   = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  output logic        if_id_valid,
  output logic [15:0] if_id_ir,
  output logic [15:0] if_id_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  localparam logic [15:0] PC_RESET_AL = PC_RESET & 16'hFFFE;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] disc_addr_q, disc_addr_d;
  logic        valid_q, valid_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] ifpc_q, ifpc_d;
  logic [15:0] skid_ir_q, skid_ir_d;
  logic [15:0] skid_pc_q, skid_pc_d;
  logic        read_q, read_d;
  logic        load;
  logic [15:0] pc_plus2;
  logic [15:0] redirect_al;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    disc_addr_d = disc_addr_q;
    valid_d     = valid_q;
    ir_d        = ir_q;
    ifpc_d      = ifpc_q;
    skid_ir_d   = skid_ir_q;
    skid_pc_d   = skid_pc_q;
    load        = 1'b0;
    pc_plus2    = pc_q + 16'd2;
    redirect_al = redirect_pc & 16'hFFFE;

    if (redirect) begin
      valid_d = 1'b0;
      ir_d    = NOP_IR;
      pc_d    = redirect_al;
      case (state_q)
        FETCH: begin
          // The in-flight request must still complete at its original address.
          if (!imem_resp) begin
            state_d     = DISCARD;
            disc_addr_d = pc_q;
          end
        end
        HOLD:    state_d = FETCH;
        DISCARD: if (imem_resp) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_resp) begin
            pc_d = pc_plus2;
            if (!valid_q || !stall) begin
              valid_d = 1'b1;
              ir_d    = imem_rdata;
              ifpc_d  = pc_plus2;
              load    = 1'b1;
            end else begin
              skid_ir_d = imem_rdata;
              skid_pc_d = pc_plus2;
              state_d   = HOLD;
            end
          end else if (!stall) begin
            valid_d = 1'b0;
            ir_d    = NOP_IR;
          end
        end
        HOLD: begin
          if (!stall) begin
            valid_d = 1'b1;
            ir_d    = skid_ir_q;
            ifpc_d  = skid_pc_q;
            load    = 1'b1;
            state_d = FETCH;
          end
        end
        DISCARD: if (imem_resp) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end

    read_d = (state_d != HOLD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FETCH;
      pc_q        <= PC_RESET_AL;
      disc_addr_q <= 16'h0000;
      valid_q     <= 1'b0;
      ir_q        <= NOP_IR;
      ifpc_q      <= 16'h0000;
      skid_ir_q   <= 16'h0000;
      skid_pc_q   <= 16'h0000;
      read_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      disc_addr_q <= disc_addr_d;
      valid_q     <= valid_d;
      ir_q        <= ir_d;
      ifpc_q      <= ifpc_d;
      skid_ir_q   <= skid_ir_d;
      skid_pc_q   <= skid_pc_d;
      read_q      <= read_d;
    end
  end

  assign imem_read    = read_q;
  assign imem_address = (state_q == DISCARD) ? disc_addr_q : pc_q;
  assign if_id_valid  = valid_q;
  assign if_id_ir     = ir_q;
  assign if_id_pc     = ifpc_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q + (load ? 32'd1 : 32'd0);
    stall_count_d = stall_count_q + ((stall && valid_q) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`else
  logic unused_load;
  assign unused_load = load;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table plus randomized run against a queue-based fetch model.
`default_nettype none

module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, redirect, imem_resp;
  logic [15:0] redirect_pc, imem_rdata;
  logic        imem_read, if_id_valid;
  logic [15:0] imem_address, if_id_ir, if_id_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, stall_count;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.PC_RESET(16'h0000), .NOP_IR(NOP)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_read(imem_read), .imem_address(imem_address),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata), .if_id_valid(if_id_valid),
    .if_id_ir(if_id_ir), .if_id_pc(if_id_pc)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [15:0] rpc;
    logic        resp;
    logic [15:0] rdata;
    logic        e_valid;
    logic [15:0] e_ir;
    logic [15:0] e_pc;
    logic        e_read;
    logic [15:0] e_addr;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic r, input logic [15:0] rp,
                              input logic rs, input logic [15:0] rd, input logic ev,
                              input logic [15:0] eir, input logic [15:0] epc,
                              input logic erd, input logic [15:0] ea);
    vec_t v;
    v.stall = s; v.redirect = r; v.rpc = rp; v.resp = rs; v.rdata = rd;
    v.e_valid = ev; v.e_ir = eir; v.e_pc = epc; v.e_read = erd; v.e_addr = ea;
    return v;
  endfunction

  vec_t vt [23];

  task automatic idle_inputs();
    stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    imem_resp = 1'b0; imem_rdata = 16'h0000;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_read", 32'(imem_read), 32'd0);
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_ir", 32'(if_id_ir), 32'(NOP));
    chk("rst_pc", 32'(if_id_pc), 32'd0);
`ifdef FETCH_PERF_EN
    chk("rst_fcnt", fetch_count, 32'd0);
    chk("rst_scnt", stall_count, 32'd0);
`endif
    reset_n = 1'b1;
  endtask

  // Reference model: PC, IF/ID contents, a skid queue and an "outstanding request is unwanted" flag.
  logic [15:0] m_pc, m_ir, m_ipc, m_daddr;
  logic        m_valid, m_drop, m_first;
  logic [31:0] skq [$];
  logic [31:0] m_fc, m_sc;

  task automatic model_init();
    m_pc = 16'h0000; m_ir = NOP; m_ipc = 16'h0000; m_daddr = 16'h0000;
    m_valid = 1'b0; m_drop = 1'b0; m_first = 1'b1;
    skq.delete(); m_fc = 32'd0; m_sc = 32'd0;
  endtask

  task automatic model_step();
    logic fetching;
    fetching = (skq.size() == 0) && !m_drop;
    if (stall && m_valid) m_sc = m_sc + 32'd1;
    if (redirect) begin
      if (fetching && !imem_resp) begin
        m_drop  = 1'b1;
        m_daddr = m_pc;
      end else if (m_drop && imem_resp) begin
        m_drop = 1'b0;
      end
      skq.delete();
      m_valid = 1'b0;
      m_ir    = NOP;
      m_pc    = redirect_pc & 16'hFFFE;
    end else if (skq.size() != 0) begin
      if (!stall) begin
        {m_ir, m_ipc} = skq.pop_front();
        m_valid = 1'b1;
        m_fc = m_fc + 32'd1;
      end
    end else if (m_drop) begin
      if (imem_resp) m_drop = 1'b0;
    end else if (imem_resp) begin
      if (!m_valid || !stall) begin
        m_valid = 1'b1;
        m_ir    = imem_rdata;
        m_ipc   = m_pc + 16'd2;
        m_fc    = m_fc + 32'd1;
      end else begin
        skq.push_back({imem_rdata, 16'(m_pc + 16'd2)});
      end
      m_pc = m_pc + 16'd2;
    end else if (!stall) begin
      m_valid = 1'b0;
      m_ir    = NOP;
    end
    m_first = 1'b0;
  endtask

  initial begin
    logic exp_read;
    logic seen;

    vt[0]  = mk(0,0,16'h0000,0,16'h0000, 0,NOP,     16'h0000, 1,16'h0000);
    vt[1]  = mk(0,0,16'h0000,0,16'h0000, 0,NOP,     16'h0000, 1,16'h0000);
    vt[2]  = mk(0,0,16'h0000,1,16'h1234, 1,16'h1234,16'h0002, 1,16'h0002);
    vt[3]  = mk(1,0,16'h0000,0,16'h0000, 1,16'h1234,16'h0002, 1,16'h0002);
    vt[4]  = mk(1,0,16'h0000,1,16'h5678, 1,16'h1234,16'h0002, 0,16'h0000);
    vt[5]  = mk(1,0,16'h0000,0,16'h0000, 1,16'h1234,16'h0002, 0,16'h0000);
    vt[6]  = mk(0,0,16'h0000,0,16'h0000, 1,16'h5678,16'h0004, 1,16'h0004);
    vt[7]  = mk(0,1,16'h3000,0,16'h0000, 0,NOP,     16'h0004, 1,16'h0004);
    vt[8]  = mk(0,0,16'h0000,0,16'h0000, 0,NOP,     16'h0004, 1,16'h0004);
    vt[9]  = mk(0,0,16'h0000,1,16'hDEAD, 0,NOP,     16'h0004, 1,16'h3000);
    vt[10] = mk(0,0,16'h0000,1,16'h1111, 1,16'h1111,16'h3002, 1,16'h3002);
    vt[11] = mk(1,1,16'hFFFF,0,16'h0000, 0,NOP,     16'h3002, 1,16'h3002);
    vt[12] = mk(0,0,16'h0000,1,16'hBEEF, 0,NOP,     16'h3002, 1,16'hFFFE);
    vt[13] = mk(0,0,16'h0000,1,16'h2222, 1,16'h2222,16'h0000, 1,16'h0000);
    vt[14] = mk(0,0,16'h0000,1,16'h3333, 1,16'h3333,16'h0002, 1,16'h0002);
    vt[15] = mk(0,1,16'h0100,1,16'h4444, 0,NOP,     16'h0002, 1,16'h0100);
    vt[16] = mk(0,0,16'h0000,0,16'h0000, 0,NOP,     16'h0002, 1,16'h0100);
    vt[17] = mk(0,0,16'h0000,1,16'h5555, 1,16'h5555,16'h0102, 1,16'h0102);
    vt[18] = mk(0,0,16'h0000,0,16'h0000, 0,NOP,     16'h0102, 1,16'h0102);
    vt[19] = mk(0,0,16'h0000,1,16'h6666, 1,16'h6666,16'h0104, 1,16'h0104);
    vt[20] = mk(1,0,16'h0000,1,16'h7777, 1,16'h6666,16'h0104, 0,16'h0000);
    vt[21] = mk(1,1,16'h0200,0,16'h0000, 0,NOP,     16'h0104, 1,16'h0200);
    vt[22] = mk(0,0,16'h0000,1,16'h8888, 1,16'h8888,16'h0202, 1,16'h0202);

    do_reset();
    for (int i = 0; i < 23; i++) begin
      stall = vt[i].stall; redirect = vt[i].redirect; redirect_pc = vt[i].rpc;
      imem_resp = vt[i].resp; imem_rdata = vt[i].rdata;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 32'(if_id_valid), 32'(vt[i].e_valid));
      chk($sformatf("v%0d_ir", i), 32'(if_id_ir), 32'(vt[i].e_ir));
      chk($sformatf("v%0d_pc", i), 32'(if_id_pc), 32'(vt[i].e_pc));
      chk($sformatf("v%0d_read", i), 32'(imem_read), 32'(vt[i].e_read));
      if (vt[i].e_read) chk($sformatf("v%0d_addr", i), 32'(imem_address), 32'(vt[i].e_addr));
      @(negedge clk);
    end
    idle_inputs();
`ifdef FETCH_PERF_EN
    chk("tbl_fcnt", fetch_count, 32'd8);
    chk("tbl_scnt", stall_count, 32'd6);
`endif

    do_reset();
    model_init();
    for (int c = 0; c < 3000; c++) begin
      exp_read = !m_first && (skq.size() == 0);
      chk("rnd_read", 32'(imem_read), 32'(exp_read));
      if (exp_read) chk("rnd_addr", 32'(imem_address), 32'(m_drop ? m_daddr : m_pc));
      chk("rnd_addr0", 32'(imem_address[0]), 32'd0);
      chk("rnd_valid", 32'(if_id_valid), 32'(m_valid));
      chk("rnd_ir", 32'(if_id_ir), 32'(m_ir));
      chk("rnd_pc", 32'(if_id_pc), 32'(m_ipc));
`ifdef FETCH_PERF_EN
      chk("rnd_fcnt", fetch_count, m_fc);
      chk("rnd_scnt", stall_count, m_sc);
`endif
      stall       = ($urandom_range(0, 2) == 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = 16'($urandom);
      imem_resp   = imem_read && ($urandom_range(0, 1) == 1);
      imem_rdata  = 16'($urandom);
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    // Asynchronous reset landing while a request is outstanding.
    idle_inputs();
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (imem_read) seen = 1'b1;
      else @(negedge clk);
    end
    chk("mid_wait_read", 32'(seen), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_read", 32'(imem_read), 32'd0);
    chk("mid_valid", 32'(if_id_valid), 32'd0);
    chk("mid_ir", 32'(if_id_ir), 32'(NOP));
    chk("mid_pc", 32'(if_id_pc), 32'd0);
`ifdef FETCH_PERF_EN
    chk("mid_fcnt", fetch_count, 32'd0);
    chk("mid_scnt", stall_count, 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
